// File: rtl/mixer_pkg.sv
// Shared types and defaults for the mixer datapath and its downstream consumers.
package mixer_pkg;

  localparam int MIX_OUT_W     = 25;
  localparam int MIX_VOL_SHIFT = 7;

  typedef logic signed [MIX_OUT_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SCALE,
    DONE
  } mix_state_t;

endpackage

// File: rtl/voice_mixer_sat_scale.sv
// Combinational gain post-processing: arithmetic shift of a product, then clamp to OUT_W.
module sat_scale #(
  parameter int IN_W  = 36,
  parameter int OUT_W = 25,
  parameter int SHIFT = 7
) (
  input  logic signed [IN_W-1:0]  prod,
  output logic signed [OUT_W-1:0] result
);

  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W-1:0] scaled;

  always_comb begin
    scaled = prod >>> SHIFT;
    if (scaled > MAX_V)
      result = MAX_V[OUT_W-1:0];
    else if (scaled < MIN_V)
      result = MIN_V[OUT_W-1:0];
    else
      result = scaled[OUT_W-1:0];
  end

endmodule

// File: rtl/voice_mixer.sv
// Polyphonic voice mixer: snapshots voices on a sample tick, sums active voices serially,
// applies master volume with saturation, and strobes out_valid for one cycle.
module voice_mixer
  import mixer_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int VOICE_W    = 24,
  parameter int OUT_W      = MIX_OUT_W,
  parameter int VOL_SHIFT  = MIX_VOL_SHIFT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sample_tick,
  input  logic [NUM_VOICES*VOICE_W-1:0] voice_samples,
  input  logic [NUM_VOICES-1:0]         voice_active,
  input  logic [7:0]                    volume,
  output logic signed [OUT_W-1:0]       mixer_output,
  output logic                          out_valid,
  output logic                          busy,
  output logic                          overrun
);

  localparam int IDX_W  = $clog2(NUM_VOICES);
  localparam int ACC_W  = VOICE_W + IDX_W;
  localparam int PROD_W = ACC_W + 9;

  mix_state_t                    state;
  logic [NUM_VOICES*VOICE_W-1:0] snap_samples;
  logic [NUM_VOICES-1:0]         snap_active;
  logic [7:0]                    snap_vol;
  logic [IDX_W-1:0]              idx;
  logic signed [ACC_W-1:0]       acc;
  logic signed [PROD_W-1:0]      prod;
  logic signed [VOICE_W-1:0]     cur_voice;
  logic signed [OUT_W-1:0]       sat_out;

  assign cur_voice = snap_samples[idx*VOICE_W +: VOICE_W];
  assign busy      = (state != IDLE);

  sat_scale #(
    .IN_W  (PROD_W),
    .OUT_W (OUT_W),
    .SHIFT (VOL_SHIFT)
  ) u_sat_scale (
    .prod   (prod),
    .result (sat_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      snap_samples <= '0;
      snap_active  <= '0;
      snap_vol     <= '0;
      idx          <= '0;
      acc          <= '0;
      prod         <= '0;
      mixer_output <= '0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      // A tick seen in any non-idle state, DONE included, is dropped and flagged.
      if (sample_tick && state != IDLE)
        overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (sample_tick) begin
            snap_samples <= voice_samples;
            snap_active  <= voice_active;
            snap_vol     <= volume;
            acc          <= '0;
            idx          <= '0;
            state        <= ACCUM;
          end
        end
        ACCUM: begin
          if (snap_active[idx])
            acc <= acc + $signed({{(ACC_W-VOICE_W){cur_voice[VOICE_W-1]}}, cur_voice});
          idx <= idx + IDX_W'(1);
          if (idx == IDX_W'(NUM_VOICES-1))
            state <= SCALE;
        end
        SCALE: begin
          prod  <= acc * $signed({1'b0, snap_vol});
          state <= DONE;
        end
        DONE: begin
          mixer_output <= sat_out;
          out_valid    <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_mixer.sv
// Directed self-checking bench for voice_mixer with hand-computed expected results.
module tb_voice_mixer;

  logic               clk;
  logic               reset;
  logic               sample_tick;
  logic [8*24-1:0]    voice_samples;
  logic [7:0]         voice_active;
  logic [7:0]         volume;
  logic signed [24:0] mixer_output;
  logic               out_valid;
  logic               busy;
  logic               overrun;

  int n_cmp  = 0;
  int n_fail = 0;

  voice_mixer #(
    .NUM_VOICES (8),
    .VOICE_W    (24),
    .OUT_W      (25),
    .VOL_SHIFT  (7)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_tick   (sample_tick),
    .voice_samples (voice_samples),
    .voice_active  (voice_active),
    .volume        (volume),
    .mixer_output  (mixer_output),
    .out_valid     (out_valid),
    .busy          (busy),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_voices(input int v0, input int others);
    int v;
    for (int i = 0; i < 8; i++) begin
      v = (i == 0) ? v0 : others;
      voice_samples[i*24 +: 24] = v[23:0];
    end
  endtask

  // Tick at E0; optional second tick / reset at edge En; expect out_valid right after exp_edge (0 = never).
  task automatic frame(input string tag, input int tick2, input int rst_at,
                       input int exp_edge, input longint exp_val);
    int got_edge = 0;
    int extra    = 0;
    @(negedge clk);
    sample_tick = 1'b1;
    @(posedge clk);
    #1;
    sample_tick   = 1'b0;
    voice_samples = {8{24'h123456}};
    voice_active  = 8'hFF;
    volume        = 8'd200;
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      if (e == tick2)  sample_tick = 1'b1;
      if (e == rst_at) reset = 1'b1;
      @(posedge clk);
      #1;
      sample_tick = 1'b0;
      reset       = 1'b0;
      if (e == 1) check({tag, ".busy_e1"}, busy, 1);
      if (exp_edge > 0 && e == exp_edge - 1) check({tag, ".busy_pre"}, busy, 1);
      if (exp_edge > 0 && e == exp_edge) check({tag, ".busy_done"}, busy, 0);
      if (out_valid) begin
        if (got_edge == 0) begin
          got_edge = e;
          check({tag, ".value"}, mixer_output, exp_val);
        end else begin
          extra++;
        end
      end
    end
    check({tag, ".valid_edge"}, got_edge, exp_edge);
    check({tag, ".extra_valid"}, extra, 0);
  endtask

  initial begin
    int nvalid;
    reset         = 1'b1;
    sample_tick   = 1'b0;
    voice_samples = '0;
    voice_active  = '0;
    volume        = '0;
    repeat (2) @(posedge clk);

    @(negedge clk);
    reset       = 1'b1;
    sample_tick = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.out", mixer_output, 0);
    check("rst.valid", out_valid, 0);
    check("rst.busy", busy, 0);
    check("rst.overrun", overrun, 0);
    @(negedge clk);
    reset       = 1'b0;
    sample_tick = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) nvalid++;
    end
    check("rst.no_valid", nvalid, 0);
    check("rst.idle", busy, 0);

    set_voices(1000, 5555); voice_active = 8'h01; volume = 8'd128;
    frame("unity", 0, 0, 10, 1000);

    set_voices(1000, 1000); voice_active = 8'h05; volume = 8'd128;
    frame("mask_v128", 0, 0, 10, 2000);
    set_voices(1000, 1000); voice_active = 8'h05; volume = 8'd64;
    frame("mask_v64", 0, 0, 10, 1000);
    set_voices(1000, 1000); voice_active = 8'h05; volume = 8'd0;
    frame("mask_v0", 0, 0, 10, 0);
    set_voices(1000, 1000); voice_active = 8'h00; volume = 8'd128;
    frame("none_active", 0, 0, 10, 0);

    set_voices(-3, 0); voice_active = 8'h01; volume = 8'd64;
    frame("neg_floor", 0, 0, 10, -2);

    set_voices(8388607, 8388607); voice_active = 8'hFF; volume = 8'd255;
    frame("sat_pos", 0, 0, 10, 16777215);
    set_voices(-8388608, -8388608); voice_active = 8'hFF; volume = 8'd128;
    frame("sat_neg", 0, 0, 10, -16777216);

    check("no_overrun_yet", overrun, 0);

    set_voices(1000, 5555); voice_active = 8'h01; volume = 8'd128;
    frame("overrun", 4, 0, 10, 1000);
    check("overrun.set", overrun, 1);
    repeat (5) @(posedge clk);
    #1;
    check("overrun.sticky", overrun, 1);

    set_voices(1000, 5555); voice_active = 8'h01; volume = 8'd128;
    frame("midrst", 0, 5, 0, 0);
    check("midrst.overrun", overrun, 0);
    check("midrst.busy", busy, 0);

    set_voices(1000, 5555); voice_active = 8'h01; volume = 8'd128;
    frame("after_rst", 0, 0, 10, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
